// File: rtl/verificador_tabuleiro.sv
// verificador_tabuleiro: scans one 3x3 micro board from the board RAM and reports winner, draw or open
module verificador_tabuleiro #(
   parameter int CELL_W = 2,
   parameter int ADDR_W = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar_verif,
   input  logic [3:0]        macro_sel,
   input  logic [CELL_W-1:0] ram_dado,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd_en,
   output logic              ocupado,
   output logic              pronto,
   output logic [1:0]        vencedor,
   output logic              empate,
   output logic [7:0]        linha_vencedora,
   output logic              erro
);
   typedef enum logic [2:0] {IDLE, LEITURA, CAPTURA, AVALIA, FIM} estado_t;
   estado_t estado, prox;
   logic [3:0] k;
   logic [CELL_W-1:0] cel [9];
   logic [7:0][1:0] dono;
   logic [7:0] linhas;
   logic [1:0] venc_c;
   logic cheio, invalido;
   assign invalido = macro_sel > 4'd8;
   function automatic logic [1:0] dono_linha(input logic [CELL_W-1:0] a, b, c);
      return (a == b && b == c && (a[0] ^ a[1])) ? a[1:0] : 2'b00;
   endfunction
   // state register
   always_ff @(posedge clock)
      if (!reset) estado <= IDLE;
      else estado <= prox;
   // next state and strobes
   always_comb begin
      prox = estado;
      ram_rd_en = 1'b0;
      ocupado = 1'b1;
      pronto = 1'b0;
      case (estado)
         IDLE: begin
            ocupado = 1'b0;
            if (iniciar_verif) prox = invalido ? FIM : LEITURA;
         end
         LEITURA: begin
            ram_rd_en = 1'b1;
            if (k == 4'd8) prox = CAPTURA;
         end
         CAPTURA: prox = AVALIA;
         AVALIA: prox = FIM;
         FIM: begin
            pronto = 1'b1;
            prox = IDLE;
         end
         default: prox = IDLE;
      endcase
   end
   // line evaluation over the shadow cells; 11 never completes a line nor fills a cell
   always_comb begin
      dono[0] = dono_linha(cel[0], cel[1], cel[2]);
      dono[1] = dono_linha(cel[3], cel[4], cel[5]);
      dono[2] = dono_linha(cel[6], cel[7], cel[8]);
      dono[3] = dono_linha(cel[0], cel[3], cel[6]);
      dono[4] = dono_linha(cel[1], cel[4], cel[7]);
      dono[5] = dono_linha(cel[2], cel[5], cel[8]);
      dono[6] = dono_linha(cel[0], cel[4], cel[8]);
      dono[7] = dono_linha(cel[2], cel[4], cel[6]);
      linhas = '0;
      venc_c = '0;
      cheio = 1'b1;
      for (int i = 0; i < 8; i++) begin
         linhas[i] = |dono[i];
         venc_c = venc_c | dono[i];
      end
      for (int i = 0; i < 9; i++) cheio = cheio & (cel[i][0] ^ cel[i][1]);
   end
   // address counter, cell shift register and registered results
   always_ff @(posedge clock) begin
      if (!reset) begin
         ram_addr <= '0;
         k <= '0;
         vencedor <= '0;
         empate <= 1'b0;
         linha_vencedora <= '0;
         erro <= 1'b0;
         for (int i = 0; i < 9; i++) cel[i] <= '0;
      end else begin
         if (estado == IDLE && iniciar_verif) begin
            vencedor <= '0;
            empate <= 1'b0;
            linha_vencedora <= '0;
            erro <= invalido;
            k <= '0;
            if (!invalido) ram_addr <= ADDR_W'(macro_sel) * ADDR_W'(9);
         end
         if (estado == LEITURA) begin
            k <= k + 4'd1;
            if (k != 4'd8) ram_addr <= ram_addr + ADDR_W'(1);
         end
         if ((estado == LEITURA && k != 4'd0) || estado == CAPTURA) begin
            for (int i = 0; i < 8; i++) cel[i] <= cel[i+1];
            cel[8] <= ram_dado;
         end
         if (estado == AVALIA) begin
            vencedor <= venc_c;
            linha_vencedora <= linhas;
            empate <= venc_c == 2'b00 && cheio;
         end
      end
   end
endmodule

// File: doc/verificador_tabuleiro.md
Name: verificador_tabuleiro

Overview:
Sequencer that scans one 3x3 micro board from the shared board-state RAM after each move and reports the outcome: winner, draw or still open.
- Issues nine sequential RAM reads, evaluates the 8 winning lines and returns a registered result with a one-cycle `pronto` pulse.
- Sits between `unidade_controle` (start/result handshake) and the board RAM read port inside `fluxo_dados`.

Parameters:
- CELL_W, 2, bits per cell: 00 empty, 01 player 1, 10 player 2, 11 invalid (treated as empty).
- ADDR_W, 7, RAM address width; 81 cells, address = macro*9 + micro.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- iniciar_verif  input  1  start request, sampled only in IDLE.
- macro_sel  input  4  micro board to scan (0..8), latched on start.
- ram_dado  input  CELL_W  RAM read data, valid 1 cycle after ram_addr/ram_rd_en.
- ram_addr  output  ADDR_W  RAM read address.
- ram_rd_en  output  1  RAM read strobe.
- ocupado  output  1  high from the start-accept cycle+1 until DONE inclusive.
- pronto  output  1  one-cycle pulse; result outputs valid from this cycle.
- vencedor  output  2  00 none, 01 player 1, 10 player 2, 11 both (conflict).
- empate  output  1  all 9 cells occupied and no winner.
- linha_vencedora  output  8  bitmask of completed lines: bits 0-2 rows, 3-5 columns, 6 main diagonal (0,4,8), 7 anti-diagonal (2,4,6).
- erro  output  1  macro_sel > 8 at start.

Behaviour:
- Reset (reset=0 at a clock edge), from any state including mid-scan:
  - state IDLE;
  - ram_rd_en=0, ram_addr=0, ocupado=0, pronto=0;
  - vencedor=00, empate=0, linha_vencedora=0, erro=0;
  - cell shadow registers cleared.
- FSM states: IDLE, LEITURA, CAPTURA, AVALIA, FIM.
- Start: cycle T, IDLE, iniciar_verif=1.
  - Latch macro_sel; clear vencedor, empate, linha_vencedora and erro.
  - If macro_sel > 8: go to FIM with erro=1 and no RAM reads; pronto at T+1.
  - Otherwise go to LEITURA with k=0.
- LEITURA, cycles T+1..T+9:
  - ram_rd_en=1, ram_addr = base + k, where base = macro_sel*9 (computed in ADDR_W bits, maximum 80, no overflow).
  - k increments 0..8; leave after k=8.
  - ram_dado arriving at cycle T+1+j is stored into cell[j-1] for j=1..8.
- CAPTURA, cycle T+10: ram_rd_en=0; store ram_dado into cell[8].
- AVALIA, cycle T+11: combinational evaluation of the 8 lines over the shadow cells, registered at the end of the cycle.
  - A line is complete when its three cells are equal and are 01 or 10.
  - Cell value 11 counts as empty: it is never part of a line and never counts as occupied.
  - vencedor[0] = any line complete with 01; vencedor[1] = any line complete with 10.
  - empate = (vencedor==00) AND all cells in {01,10}.
- FIM, cycle T+12: pronto=1 for exactly this cycle; return to IDLE.
  - Latency is exactly 12 cycles from start sample to pronto; 1 cycle on the erro path.
- Results hold after pronto until the next accepted start or reset.
- iniciar_verif while not in IDLE is ignored, not queued. iniciar_verif held high re-triggers one scan per return to IDLE.
- ram_addr holds its last value when ram_rd_en=0.

Test Plan:
1. Reset is low for 2 cycles, then high with no start → all outputs 0; ram_rd_en stays 0 for 20 cycles.
2. macro_sel=4, RAM cells 36..44 = {01,01,01, 00,10,00, 10,00,00}, start at T → ram_addr 36..44 on T+1..T+9; pronto only at T+12; vencedor=01, linha_vencedora=8'h01, empate=0.
3. macro_sel=8, cells 72..80 = {10,01,01, 01,10,10, 01,01,10} → vencedor=10, linha_vencedora=8'h40 (main diagonal), last address 80, no wrap.
4. macro_sel=0, cells 0..8 = {01,10,01, 01,10,10, 10,01,01} → vencedor=00, empate=1. Repeat with cell 4 = 11 → empate=0.
5. macro_sel=9 → pronto at T+1, erro=1, ram_rd_en never asserted. A start pulse during a valid scan's LEITURA is ignored and exactly one pronto is observed.
6. reset=0 at T+5 of a scan → next cycle IDLE, ram_rd_en=0, no pronto. A subsequent start completes normally with a correct result.
